// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write sequencer: power-up wait, 4-command init,
// then 17-write frames (line-2 address + 16 chars) on refresh.
module lcd_ctrl #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_EH    = 12,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh,
  output logic [1:0] init_set,
  output logic [3:0] mux_sel,
  output logic       data_sel,
  output logic       DB_sel,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       ready
);

  typedef enum logic [1:0] {
    S_PWRUP, S_INIT, S_FRAME, S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP, P_STROBE, P_WAIT
  } phase_t;

  localparam logic [19:0] PWR_M1 = 20'(T_PWRUP - 1);
  localparam logic [19:0] EH_M1  = 20'(T_EH - 1);
  localparam logic [19:0] CMD_M1 = 20'(T_CMD - 1);
  localparam logic [19:0] CLR_M1 = 20'(T_CLR - 1);

  state_t      r_state;
  phase_t      r_ph;
  logic [19:0] r_cnt;
  logic        r_pend;
  logic        r_addr;

  logic [19:0] w_wait;
  logic        w_frame_go;

  // Clear-display (init index 2) needs the long settle time.
  assign w_wait = (r_state == S_INIT && init_set == 2'd2)
                ? CLR_M1 : CMD_M1;
  assign w_frame_go = r_pend | refresh;
  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_PWRUP;
      r_ph     <= P_SETUP;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_addr   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      init_set <= 2'd0;
      mux_sel  <= 4'd0;
      data_sel <= 1'b0;
      DB_sel   <= 1'b1;
      ready    <= 1'b0;
    end else begin
      if (refresh && r_state != S_IDLE)
        r_pend <= 1'b1;
      unique case (r_state)
        S_PWRUP: begin
          if (r_cnt == PWR_M1) begin
            r_state <= S_INIT;
            r_ph    <= P_SETUP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_IDLE: begin
          if (refresh) begin
            r_state  <= S_FRAME;
            r_ph     <= P_SETUP;
            r_addr   <= 1'b1;
            DB_sel   <= 1'b0;
            lcd_rs   <= 1'b0;
            data_sel <= 1'b1;
            mux_sel  <= 4'd0;
            ready    <= 1'b0;
          end
        end
        default: begin
          unique case (r_ph)
            P_SETUP: begin
              r_ph  <= P_STROBE;
              r_cnt <= EH_M1;
              lcd_e <= 1'b1;
            end
            P_STROBE: begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - 20'd1;
              end else begin
                r_ph  <= P_WAIT;
                r_cnt <= w_wait;
                lcd_e <= 1'b0;
              end
            end
            default: begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - 20'd1;
              end else begin
                r_ph <= P_SETUP;
                if (r_state == S_INIT) begin
                  if (init_set == 2'd3) begin
                    r_state  <= S_FRAME;
                    r_addr   <= 1'b1;
                    DB_sel   <= 1'b0;
                    lcd_rs   <= 1'b0;
                    data_sel <= 1'b1;
                    mux_sel  <= 4'd0;
                  end else begin
                    init_set <= init_set + 2'd1;
                  end
                end else if (r_addr) begin
                  r_addr <= 1'b0;
                  DB_sel <= 1'b1;
                  lcd_rs <= 1'b1;
                end else if (mux_sel != 4'd15) begin
                  mux_sel <= mux_sel + 4'd1;
                end else begin
                  // Frame done: a merged request restarts immediately.
                  mux_sel <= 4'd0;
                  r_pend  <= 1'b0;
                  if (w_frame_go) begin
                    r_addr <= 1'b1;
                    DB_sel <= 1'b0;
                    lcd_rs <= 1'b0;
                  end else begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                  end
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: strobe log compared against a write-list model
// with absolute expected strobe cycles.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 10;
  localparam int T_EH    = 2;
  localparam int T_CMD   = 3;
  localparam int T_CLR   = 6;
  localparam int WR      = 1 + T_EH + T_CMD;
  localparam int FLEN    = 17 * WR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       refresh = 1'b0;
  logic [1:0] init_set;
  logic [3:0] mux_sel;
  logic       data_sel, DB_sel, lcd_e, lcd_rs, lcd_rw, ready;

  lcd_ctrl #(
    .T_PWRUP(T_PWRUP), .T_EH(T_EH),
    .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .refresh(refresh),
    .init_set(init_set), .mux_sel(mux_sel),
    .data_sel(data_sel), .DB_sel(DB_sel),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  is;
    logic [3:0]  ms;
    logic        ds;
    logic        db;
    logic        rs;
  } wr_t;

  wr_t  obs[$];
  wr_t  exp_q[$];
  int   rdy_q[$];
  int   cyc;
  int   t_next;
  int   n_chk = 0;
  int   n_pass = 0;
  int   stable_err = 0;
  int   rw_err = 0;
  logic prev_e = 1'b0;
  logic prev_rdy = 1'b0;
  logic [8:0] prev_sel = '0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  // Strobe/ready logger; fields irrelevant to a write kind are zeroed.
  always @(negedge clk) begin : mon
    wr_t w;
    logic [8:0] sel;
    sel = {init_set, mux_sel, data_sel, DB_sel, lcd_rs};
    if (lcd_rw !== 1'b0) rw_err <= rw_err + 1;
    if (lcd_e && sel !== prev_sel) stable_err <= stable_err + 1;
    if (rst_n && lcd_e && !prev_e) begin
      w.cyc = cyc;
      w.is = init_set;
      w.ms = mux_sel;
      w.ds = data_sel;
      w.db = DB_sel;
      w.rs = lcd_rs;
      if (!DB_sel) begin
        w.is = 0; w.ms = 0; w.ds = 0;
      end else if (data_sel) begin
        w.is = 0;
      end else begin
        w.ms = 0;
      end
      obs.push_back(w);
    end
    if (rst_n && ready && !prev_rdy) rdy_q.push_back(cyc);
    prev_e   <= lcd_e;
    prev_sel <= sel;
    prev_rdy <= ready;
  end

  function automatic void add(logic [1:0] is, logic [3:0] ms,
                              logic ds, logic db, logic rs, int w);
    wr_t e;
    e.cyc = t_next;
    e.is = is; e.ms = ms; e.ds = ds; e.db = db; e.rs = rs;
    exp_q.push_back(e);
    t_next += 1 + T_EH + w;
  endfunction

  function automatic void model_init();
    for (int k = 0; k < 4; k++)
      add(2'(k), 4'd0, 1'b0, 1'b1, 1'b0, (k == 2) ? T_CLR : T_CMD);
  endfunction

  function automatic void model_frame();
    add(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, T_CMD);
    for (int c = 0; c < 16; c++)
      add(2'd0, 4'(c), 1'b1, 1'b1, 1'b1, T_CMD);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs.delete();
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    refresh = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({lcd_e, lcd_rs, lcd_rw, init_set, mux_sel,
         data_sel, DB_sel, ready} !== 12'h002)
      $display("FAIL reset_outputs: got %h want 002",
               {lcd_e, lcd_rs, lcd_rw, init_set, mux_sel,
                data_sel, DB_sel, ready});
    else n_pass++;
  endtask

  task automatic test_init_frame();
    bit ok;
    wr_t g;
    clear_logs();
    t_next = T_PWRUP + 1;
    model_init();
    model_frame();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(400, ok);
    n_chk++;
    if (!ok) $display("FAIL init_ready_timeout: ready=%b want 1", ready);
    else n_pass++;
    n_chk++;
    if (rdy_q.size() != 1 || rdy_q[0] != t_next - 1)
      $display("FAIL init_ready_cycle: got %0d (n=%0d) want %0d",
               (rdy_q.size() > 0) ? rdy_q[0] : -1, rdy_q.size(), t_next - 1);
    else n_pass++;
    n_chk++;
    if (obs.size() != 21)
      $display("FAIL init_strobe_count: got %0d want 21", obs.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0;
      if (i < obs.size()) g = obs[i];
      n_chk++;
      if (g !== exp_q[i])
        $display("FAIL init_write%0d: got %h want %h", i, g, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_refresh_idle();
    bit ok;
    int r;
    wr_t g;
    for (int it = 0; it < 2; it++) begin
      clear_logs();
      repeat ($urandom_range(0, 5)) step();
      r = cyc + 1;
      refresh = 1'b1;
      step();
      refresh = 1'b0;
      n_chk++;
      if (ready !== 1'b0)
        $display("FAIL idle_ready_drop: got %b want 0", ready);
      else n_pass++;
      t_next = r + 1;
      model_frame();
      wait_ready(200, ok);
      n_chk++;
      if (!ok || rdy_q.size() != 1 || rdy_q[0] != t_next - 1)
        $display("FAIL idle_ready_cycle: got %0d (n=%0d) want %0d",
                 (rdy_q.size() > 0) ? rdy_q[0] : -1, rdy_q.size(), t_next - 1);
      else n_pass++;
      n_chk++;
      if (obs.size() != 17)
        $display("FAIL idle_strobe_count: got %0d want 17", obs.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        g = '0;
        if (i < obs.size()) g = obs[i];
        n_chk++;
        if (g !== exp_q[i])
          $display("FAIL idle_write%0d: got %h want %h", i, g, exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, hit;
    int r, n;
    int pulses[$];
    wr_t g;
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      pulses.delete();
      repeat ($urandom_range(0, 3)) step();
      r = cyc + 1;
      pulses.push_back(r);
      if (it < 3) begin
        n = (it == 0) ? 3 : $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          pulses.push_back(r + $urandom_range(1 + k * 34, 34 + k * 34));
      end else begin
        pulses.push_back(r + FLEN);
      end
      for (int e = r; e <= r + FLEN; e++) begin
        hit = 1'b0;
        foreach (pulses[k]) if (pulses[k] == e) hit = 1'b1;
        refresh = hit;
        step();
      end
      refresh = 1'b0;
      t_next = r + 1;
      model_frame();
      model_frame();
      wait_ready(300, ok);
      n_chk++;
      if (!ok || rdy_q.size() != 1 || rdy_q[0] != t_next - 1)
        $display("FAIL b2b%0d_ready: got %0d (n=%0d) want %0d", it,
                 (rdy_q.size() > 0) ? rdy_q[0] : -1, rdy_q.size(), t_next - 1);
      else n_pass++;
      n_chk++;
      if (obs.size() != 34)
        $display("FAIL b2b%0d_strobe_count: got %0d want 34", it, obs.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        g = '0;
        if (i < obs.size()) g = obs[i];
        n_chk++;
        if (g !== exp_q[i])
          $display("FAIL b2b%0d_write%0d: got %h want %h", it, i, g, exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    bit found;
    clear_logs();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = lcd_e && lcd_rs && (mux_sel == 4'd7);
    end
    n_chk++;
    if (!found) $display("FAIL rst_find_char7: found=%b want 1", found);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (lcd_e !== 1'b1) $display("FAIL rst_strobe_high: got %b want 1", lcd_e);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({lcd_e, lcd_rs, init_set, mux_sel, data_sel, DB_sel, ready}
        !== 11'h002)
      $display("FAIL rst_async_drop: got %h want 002",
               {lcd_e, lcd_rs, init_set, mux_sel, data_sel, DB_sel, ready});
    else n_pass++;
    repeat (3) step();
    test_init_frame();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init_frame();
    test_refresh_idle();
    test_back_to_back();
    test_reset_mid_strobe();
    n_chk++;
    if (stable_err != 0 || rw_err != 0)
      $display("FAIL continuous: stable_err=%0d rw_err=%0d want 0 0",
               stable_err, rw_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWRUP, 750000: power-up wait in clk cycles before first command (15 ms at 50 MHz).
REQ-002 Parameter T_EH, 12: lcd_e high width in cycles.
REQ-003 Parameter T_CMD, 2000: post-strobe wait for ordinary commands and data writes.
REQ-004 Parameter T_CLR, 82000: post-strobe wait for the clear-display command (init index 2).
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port refresh, input, 1: request to rewrite the 16-character line; sampled each cycle.
REQ-008 Port init_set, output, 2: init command index to the datapath.
REQ-009 Port mux_sel, output, 4: character index 0..15 to the datapath.
REQ-010 Port data_sel, output, 1: 0 selects the init command, 1 selects the character.
REQ-011 Port DB_sel, output, 1: 0 forces DB to 8'hC0 (DDRAM line-2 address), 1 passes the data_sel result.
REQ-012 Port lcd_e, output, 1: LCD enable strobe.
REQ-013 Port lcd_rs, output, 1: 0 for command, 1 for character data.
REQ-014 Port lcd_rw, output, 1: tied 0 (write only).
REQ-015 Port ready, output, 1: high only in IDLE after init completes.

Function
REQ-016 States SHALL be PWRUP, INIT, FRAME, IDLE; each write in INIT or FRAME SHALL use the sub-phases SETUP, STROBE, WAIT.
REQ-017 Write timing SHALL be: SETUP for 1 cycle (selects and lcd_rs valid, lcd_e=0), then STROBE for T_EH cycles (lcd_e=1), then WAIT for T_CMD or T_CLR cycles (lcd_e=0), so each write lasts 1+T_EH+wait cycles.
REQ-018 init_set, mux_sel, data_sel, DB_sel and lcd_rs SHALL stay constant from SETUP through the end of WAIT of each write.
REQ-019 PWRUP SHALL count T_PWRUP cycles, then enter INIT.
REQ-020 INIT SHALL issue 4 command writes with init_set=0,1,2,3 in order, data_sel=0, DB_sel=1, lcd_rs=0; index 2 SHALL use T_CLR, the others T_CMD.
REQ-021 After init index 3 completes, the block SHALL start one FRAME automatically, without needing refresh.
REQ-022 FRAME SHALL issue 17 writes: first the address command (DB_sel=0, lcd_rs=0), then characters mux_sel=0..15 (DB_sel=1, data_sel=1, lcd_rs=1), all using T_CMD.
REQ-023 After character 15 the block SHALL enter IDLE with ready=1, and mux_sel SHALL wrap to 0.
REQ-024 In IDLE, refresh=1 SHALL start a FRAME SETUP on the next cycle, with ready=0 in that cycle.
REQ-025 refresh=1 in any non-IDLE state SHALL set a single pending flag; multiple requests SHALL merge into one.
REQ-026 At frame end with the pending flag set, the next FRAME SHALL start directly without an IDLE cycle, ready SHALL stay 0, and the flag SHALL clear.
REQ-027 refresh seen in the same cycle the last WAIT ends SHALL count as pending, so no request is lost.
REQ-028 Wait counters SHALL be 20 bits, count down to 0 and never wrap; parameter values SHALL be at least 1.

Reset
REQ-029 rst_n=0 SHALL immediately force state PWRUP, counters 0, pending 0, lcd_e=0, lcd_rs=0, lcd_rw=0, init_set=0, mux_sel=0, data_sel=0, DB_sel=1, ready=0.
REQ-030 Assertion of rst_n mid-write, including with lcd_e high, SHALL drop lcd_e asynchronously; after release the full power-up and init sequence SHALL restart.

Verification (T_PWRUP=10, T_EH=2, T_CMD=3, T_CLR=6)
REQ-031 Release reset, refresh=0 -> exactly 4 init strobes with init_set 0,1,2,3, each lcd_e high 2 cycles; first strobe begins cycle 11 after release.
REQ-032 Same run -> 17 frame strobes follow (first with DB_sel=0, lcd_rs=0; then mux_sel 0..15 with lcd_rs=1); ready rises 37+102=139 cycles after release.
REQ-033 From IDLE, pulse refresh for 1 cycle -> ready=0 next cycle; 17 strobes; ready=1 after 102 cycles.
REQ-034 Pulse refresh 3 times during a frame -> exactly one extra back-to-back frame (34 strobes total); ready never high between the two frames.
REQ-035 Assert rst_n=0 during STROBE of character 7 -> lcd_e=0 in the same cycle; after release the sequence matches REQ-031.
REQ-036 Check continuously -> lcd_rw is always 0; selects never change while lcd_e=1.
